// File: rtl/jt12_ch_ctrl_if.sv
// CPU write bus for the JT12 channel controller: chip select, write strobe,
// address/part select, data byte, and the busy flag returned to the CPU.
interface jt12_ch_ctrl_if;
    logic       cs_n;
    logic       wr_n;
    logic [1:0] addr;
    logic [7:0] din;
    logic       busy;

    modport master (
        output cs_n,
        output wr_n,
        output addr,
        output din,
        input  busy
    );

    modport slave (
        input  cs_n,
        input  wr_n,
        input  addr,
        input  din,
        output busy
    );
endinterface

// File: rtl/jt12_ch_ctrl.sv
// JT12 channel-register write controller and channel-slot sequencer.
// Decodes CPU data writes into per-channel update strobes, keeps the shared
// F-number high latch, generates the CPU busy flag and rotates the channel
// index that the register file presents to the operator pipeline.
module jt12_ch_ctrl #(
    parameter int NUM_CH      = 6,
    parameter int BUSY_CYCLES = 32
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          cen,
    jt12_ch_ctrl_if.slave bus,
    output logic [7:0]    din_q,
    output logic [2:0]    up_ch,
    output logic [5:0]    latch_fnum,
    output logic          up_fnumlo,
    output logic          up_alg,
    output logic          up_pms,
    output logic [2:0]    ch,
    output logic          ch_zero
);

    // Strobe vector layout: 0 = fnum low, 1 = alg/fb, 2 = pan/ams/pms
    localparam int NUM_STB = 3;

    logic               wr_act_reg;
    logic [7:0]         sel_addr_reg;
    logic               sel_part_reg;
    logic [7:0]         din_q_reg;
    logic [2:0]         up_ch_reg;
    logic [5:0]         latch_fnum_reg;
    logic               busy_reg;
    logic [7:0]         busy_cnt_reg;
    logic [2:0]         ch_reg;
    logic [2:0]         ch_next;
    logic [NUM_STB-1:0] stb_reg;
    logic [NUM_STB-1:0] stb_next;

    logic               wr_act;
    logic               wr_acc;
    logic               addr_wr;
    logic               data_wr;
    logic [1:0]         dec_r;
    logic [5:0]         dec_grp;
    logic               dec_valid;
    logic               dec_latch;
    logic               dec_hit;

    // A held strobe must produce a single write, so only the rising edge of
    // the combined select/write condition is accepted. Data writes arriving
    // while busy are discarded; busy is the registered value, so a write on
    // the very clk that busy clears is still dropped.
    assign wr_act  = ~bus.cs_n & ~bus.wr_n;
    assign wr_acc  = wr_act & ~wr_act_reg;
    assign addr_wr = wr_acc & ~bus.addr[0];
    assign data_wr = wr_acc &  bus.addr[0] & ~busy_reg;

    // Register-address decode of the selected register for an accepted data write
    always_comb begin
        dec_r     = sel_addr_reg[1:0];
        dec_grp   = sel_addr_reg[7:2];
        dec_valid = (dec_r != 2'd3) && !((NUM_CH == 3) && sel_part_reg);
        dec_latch = 1'b0;
        stb_next  = '0;
        if (data_wr && dec_valid) begin
            case (dec_grp)
                6'h28:   stb_next[0] = 1'b1;   // 0xA0-0xA2
                6'h29:   dec_latch   = 1'b1;   // 0xA4-0xA6
                6'h2C:   stb_next[1] = 1'b1;   // 0xB0-0xB2
                6'h2D:   stb_next[2] = 1'b1;   // 0xB4-0xB6
                default: ;
            endcase
        end
        dec_hit = dec_latch | (|stb_next);
    end

    // Sample the write condition every clk for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_act_reg <= 1'b0;
        end else begin
            wr_act_reg <= wr_act;
        end
    end

    // Address latch, data copy, target channel and shared F-number high latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_addr_reg   <= 8'd0;
            sel_part_reg   <= 1'b0;
            din_q_reg      <= 8'd0;
            up_ch_reg      <= 3'd0;
            latch_fnum_reg <= 6'd0;
        end else begin
            if (addr_wr) begin
                sel_addr_reg <= bus.din;
                sel_part_reg <= bus.addr[1];
            end
            if (data_wr) begin
                din_q_reg <= bus.din;
            end
            if (dec_hit) begin
                up_ch_reg <= {sel_part_reg, dec_r};
            end
            if (dec_latch) begin
                latch_fnum_reg <= bus.din[5:0];
            end
        end
    end

    // One-clk update strobes, independent of cen
    generate
        for (genvar gi = 0; gi < NUM_STB; gi++) begin : g_stb
            // Each strobe is high for exactly the clk after its decode
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stb_reg[gi] <= 1'b0;
                end else begin
                    stb_reg[gi] <= stb_next[gi];
                end
            end
        end
    endgenerate

    // Busy counter: loaded by an accepted data write, counts down on cen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg     <= 1'b0;
            busy_cnt_reg <= 8'd0;
        end else if (data_wr) begin
            busy_reg     <= 1'b1;
            busy_cnt_reg <= 8'(BUSY_CYCLES);
        end else if (cen && busy_reg) begin
            busy_cnt_reg <= busy_cnt_reg - 8'd1;
            if (busy_cnt_reg == 8'd1) begin
                busy_reg <= 1'b0;
            end
        end
    end

    // Channel sequencer next-state: codes 3 and 7 are skipped, and any stray
    // code falls back to 0 on the next cen
    always_comb begin
        ch_next = ch_reg;
        if (cen) begin
            case (ch_reg)
                3'd0:    ch_next = 3'd1;
                3'd1:    ch_next = 3'd2;
                3'd2:    ch_next = (NUM_CH == 3) ? 3'd0 : 3'd4;
                3'd4:    ch_next = (NUM_CH == 3) ? 3'd0 : 3'd5;
                3'd5:    ch_next = (NUM_CH == 3) ? 3'd0 : 3'd6;
                default: ch_next = 3'd0;
            endcase
        end
    end

    // Channel sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_reg <= 3'd0;
        end else begin
            ch_reg <= ch_next;
        end
    end

    assign bus.busy   = busy_reg;
    assign din_q      = din_q_reg;
    assign up_ch      = up_ch_reg;
    assign latch_fnum = latch_fnum_reg;
    assign up_fnumlo  = stb_reg[0];
    assign up_alg     = stb_reg[1];
    assign up_pms     = stb_reg[2];
    assign ch         = ch_reg;
    assign ch_zero    = (ch_reg == 3'd0);

endmodule

// File: doc/jt12_ch_ctrl.md
# jt12_ch_ctrl

Channel-register write controller and channel-slot sequencer for the JT12 FM core. It decodes CPU bus writes into the update strobes, channel index and latched F-number high bits that drive the per-channel register file. It generates the CPU busy flag and rotates the "next active channel" index that the register file uses to present channel data to the operator pipeline.

## Interface
Parameters:
- NUM_CH, 6: number of FM channels; 6 (YM2612/YM2610) or 3 (YM2203).
- BUSY_CYCLES, 32: number of cen ticks that busy stays high after an accepted data write; range 1..255.

Ports:
- rst  in  1  reset; asynchronous, active-high.
- clk  in  1  single system clock; all state is on its rising edge.
- cen  in  1  clock enable for the sequencer and busy counter.
- cs_n  in  1  chip select, active-low.
- wr_n  in  1  write strobe, active-low.
- addr  in  2  {A1,A0}; A0=0 selects an address write, A0=1 a data write; A1 selects part (bank) 0/1.
- din  in  8  CPU data.
- busy  out  1  high while the chip is busy after a data write.
- din_q  out  8  registered copy of the last accepted data byte; feeds the register file data input.
- up_ch  out  3  target channel code {part, reg[1:0]} for the current update.
- latch_fnum  out  6  shared {block[2:0], fnum[10:8]} latch.
- up_fnumlo  out  1  one-clk strobe that commits {latch_fnum, din_q} to the channel.
- up_alg  out  1  one-clk strobe for the feedback/algorithm register.
- up_pms  out  1  one-clk strobe for the pan/AMS/PMS register.
- ch  out  3  next active channel code.
- ch_zero  out  1  high during the cen tick on which ch wraps to 0.

## Operation
- Write detection: wr_act = !cs_n & !wr_n is registered every clk. A write is accepted on the clk where wr_act is 1 and its previous sample was 0 (rising edge). A held strobe produces exactly one write.
- Address write (A0=0): sel_addr <= din and sel_part <= A1. This is accepted even while busy.
- Data write (A0=1) is dropped entirely while busy=1; no strobes, and din_q, latch_fnum and busy are unchanged. Otherwise din_q <= din, and the decode uses sel_addr, sel_part and r = sel_addr[1:0]:
  - If r==3, the write decodes as invalid: no strobe, no latch change, busy still starts.
  - 0xA4–0xA6: latch_fnum <= din[5:0]; no strobe.
  - 0xA0–0xA2: up_fnumlo pulses.
  - 0xB0–0xB2: up_alg pulses.
  - 0xB4–0xB6: up_pms pulses.
  - For every valid decode, up_ch <= {sel_part, r}.
  - All other addresses produce no strobe but still start busy.
- NUM_CH==3: a write with sel_part=1 produces no strobe and no latch change, but still starts busy.
- latch_fnum is a single latch shared by all channels; a later 0xA0 write on any channel consumes it.
- Busy: an accepted data write loads the counter with BUSY_CYCLES and sets busy=1. The counter decrements on each cen. busy clears on the cen tick where the counter reaches 0.
- Sequencer:
  - On each cen, ch advances through 0,1,2,4,5,6 and back to 0 when NUM_CH=6, or 0,1,2 and back to 0 when NUM_CH=3.
  - Codes 3 and 7 are never produced. If ch is ever found at 3 or 7, the next cen moves it to 0.
  - ch_zero=1 while ch==0.

## Timing
- Reset values: busy=0, din_q=0, up_ch=0, latch_fnum=0, all up_* strobes=0, ch=0, ch_zero=1, sel_addr=0, sel_part=0, busy counter=0.
- Write latency: edge on clk N, then din_q, up_ch, latch_fnum and the strobe are valid on clk N+1. Strobes last exactly one clk and are independent of cen.
- busy rises on clk N+1, the same edge as the strobe.
- A data write on the same clk that busy clears is dropped, because busy is sampled before the clear.
- The sequencer and busy counter advance only on cen; decode runs every clk.
- An asynchronous rst mid-busy or mid-strobe returns everything to reset values immediately; there is no pending state.

## Test plan
- Reset: assert rst mid-busy with ch=5 -> immediately busy=0, ch=0, strobes=0, latch_fnum=0.
- F-number write (NUM_CH=6): address 0xA4 with A1=1, data 0x2D; then address 0xA1 with A1=1, data 0x55 -> latch_fnum=0x2D, then a one-clk up_fnumlo with up_ch=5 (3'b101) and din_q=0x55.
- Busy drop: a data write to 0xB0 starts busy; a second data write to 0xB4 after 5 cen ticks -> no up_pms and din_q unchanged. busy clears after exactly 32 cen ticks (BUSY_CYCLES=32).
- Invalid and part gating: a data write to 0xB3 -> no strobe and busy=1. With NUM_CH=3, a data write to 0xB0 with A1=1 -> no strobe.
- Sequencer: 12 cen pulses with NUM_CH=6 -> ch goes 1,2,4,5,6,0,1,2,4,5,6,0 and ch_zero is high on the two 0 entries. With NUM_CH=3 -> 1,2,0 repeating.
- Held strobe: wr_n held low for 10 clk on a data write to 0xB5 -> exactly one up_pms pulse with up_ch=1.
